// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: packet field positions,
// packet width and the controller state encoding.
package mem_access_pkg;

    localparam int PKT_W    = 42;

    localparam int WE_BIT   = 0;
    localparam int RD_BIT   = 1;
    localparam int RES_LSB  = 2;
    localparam int RES_MSB  = 33;
    localparam int DEST_LSB = 34;
    localparam int DEST_MSB = 36;
    localparam int WR_BIT   = 37;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // A packet needs the memory port if it reads or writes memory.
    function automatic logic is_mem(input logic [PKT_W-1:0] pkt);
        return pkt[RD_BIT] | pkt[WR_BIT];
    endfunction

endpackage

// File: rtl/mem_access.sv
// Memory-access pipeline stage. Non-memory packets pass straight through
// with one cycle of latency; loads and stores hold the stage in ACCESS
// until the memory acknowledges or the wait counter expires.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a packet; ALU packets forwarded every cycle
// ST_ACCESS | mem_req held, waiting for mem_ack or timeout
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PKT_W-1:0]  exec_in,
    input  logic [31:0]       store_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              out_valid,
    output logic [PKT_W-1:0]  exec_out,
    output logic [31:0]       data_in,
    output logic              err
);

    // The wait counter is nominally 6 bits; it widens only when TIMEOUT
    // exceeds what 6 bits can count, so large settings still time out.
    localparam int            CNT_W   = (TIMEOUT > 64) ? 8 : 6;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [PKT_W-1:0]   pkt_q,       pkt_d;
    logic [31:0]        wdata_q,     wdata_d;
    logic               we_q,        we_d;
    logic [PKT_W-1:0]   exec_out_q,  exec_out_d;
    logic [31:0]        data_in_q,   data_in_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q,       err_d;

    // Next-state and datapath update for the access controller.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pkt_d       = pkt_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        exec_out_d  = exec_out_q;
        data_in_d   = data_in_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_mem(exec_in)) begin
                        state_d = ST_ACCESS;
                        cnt_d   = '0;
                        pkt_d   = exec_in;
                        wdata_d = store_data;
                        // A packet flagged both read and write is a load.
                        we_d    = exec_in[WR_BIT] & ~exec_in[RD_BIT];
                    end else begin
                        exec_out_d  = exec_in;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // An ack on the final wait cycle still counts as success.
                if (mem_ack) begin
                    state_d     = ST_IDLE;
                    exec_out_d  = pkt_q;
                    out_valid_d = 1'b1;
                    if (!we_q) begin
                        data_in_d = mem_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d            = ST_IDLE;
                    exec_out_d         = pkt_q;
                    exec_out_d[WE_BIT] = 1'b0;
                    out_valid_d        = 1'b1;
                    err_d              = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pkt_q       <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            exec_out_q  <= '0;
            data_in_q   <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pkt_q       <= pkt_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            exec_out_q  <= exec_out_d;
            data_in_q   <= data_in_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign mem_req   = (state_q == ST_ACCESS);
    assign mem_we    = we_q;
    assign mem_addr  = pkt_q[RES_MSB:RES_LSB];
    assign mem_wdata = wdata_q;
    assign out_valid = out_valid_q;
    assign exec_out  = exec_out_q;
    assign data_in   = data_in_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: the driver pushes the expected writeback
// for each packet, a monitor pops and compares on every out_valid.
module tb_mem_access;

    localparam int TO = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [41:0] exec_in;
    logic [31:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [41:0] exec_out;
    logic [31:0] data_in;
    logic        err;

    typedef struct {
        logic [41:0] pkt;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_data;   // model of the writeback data register
    int          n_tests;
    int          n_fail;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exec_in    (exec_in),
        .store_data (store_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .out_valid  (out_valid),
        .exec_out   (exec_out),
        .data_in    (data_in),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [41:0] mk(input logic we, input logic rd, input logic wr,
                                       input logic [31:0] res, input logic [2:0] dest,
                                       input logic [3:0] rsv);
        return {rsv, wr, dest, res, rd, we};
    endfunction

    // Monitor: every writeback pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("exec_out", 64'(exec_out), 64'(e.pkt));
                chk("data_in",  64'(data_in),  64'(e.data));
                chk("err",      64'(err),      64'(e.err));
            end
        end
        if (rst_n && err && !out_valid) begin
            chk("err_without_out_valid", 64'(err), 64'd0);
        end
    end

    // ALU packet: leaves in_valid high so consecutive calls are back-to-back.
    task automatic send_alu(input logic [41:0] p);
        exp_t e;
        chk("in_ready_alu", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        exec_in    = p;
        store_data = $urandom;
        e.pkt  = p;
        e.data = exp_data;
        e.err  = 1'b0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        chk("alu_no_mem_req", 64'(mem_req), 64'd0);
        chk("alu_out_valid",  64'(out_valid), 64'd1);
    endtask

    // Memory packet: ack_at is the ACCESS cycle index (0 = first cycle of
    // mem_req) of the ack; ack_at >= TO means the memory never answers.
    task automatic send_mem(input logic [41:0] p, input logic [31:0] sd, input int ack_at,
                            input logic [31:0] rd, output int req_cycles);
        exp_t e;
        logic is_store;
        is_store = p[37] && !p[1];
        chk("in_ready_mem", 64'(in_ready), 64'd1);
        in_valid   = 1'b1;
        exec_in    = p;
        store_data = sd;
        e.pkt = p;
        e.err = 1'b0;
        if (ack_at < TO) begin
            if (!is_store) exp_data = rd;
        end else begin
            e.pkt[0] = 1'b0;
            e.err    = 1'b1;
        end
        e.data = exp_data;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        exec_in    = {$urandom, $urandom};
        store_data = $urandom;
        req_cycles = 0;
        for (int k = 0; k < TO; k++) begin
            if (mem_req) req_cycles++;
            chk("mem_req_held",   64'(mem_req),  64'd1);
            chk("in_ready_busy",  64'(in_ready), 64'd0);
            chk("mem_addr",       64'(mem_addr), 64'(p[33:2]));
            chk("mem_we",         64'(mem_we),   64'(is_store));
            if (is_store) chk("mem_wdata", 64'(mem_wdata), 64'(sd));
            if (k == ack_at) begin
                mem_ack   = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_rdata = $urandom;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (k == ack_at) break;
        end
        chk("mem_req_released", 64'(mem_req),  64'd0);
        chk("in_ready_after",   64'(in_ready), 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc;
        n_tests    = 0;
        n_fail     = 0;
        exp_data   = '0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        exec_in    = '0;
        store_data = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_mem_req",   64'(mem_req),   64'd0);
        chk("rst_mem_we",    64'(mem_we),    64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_err",       64'(err),       64'd0);
        chk("rst_mem_addr",  64'(mem_addr),  64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_exec_out",  64'(exec_out),  64'd0);
        chk("rst_data_in",   64'(data_in),   64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Back-to-back ALU packets.
        send_alu(mk(1'b1, 1'b0, 1'b0, 32'h0000_0005, 3'd3, 4'h0));
        send_alu(mk(1'b1, 1'b0, 1'b0, 32'h0000_000A, 3'd4, 4'h0));
        idle(2);

        // Load with ack three cycles after mem_req rises.
        send_mem(mk(1'b1, 1'b1, 1'b0, 32'h0000_0100, 3'd5, 4'hA), 32'h0, 3, 32'hDEAD_BEEF, rc);
        idle(2);

        // Store: data_in must be untouched.
        send_mem(mk(1'b0, 1'b0, 1'b1, 32'h0000_0040, 3'd0, 4'h5), 32'h1234_5678, 2, 32'hCAFE_F00D, rc);
        idle(1);

        // Load that is never acknowledged.
        send_mem(mk(1'b1, 1'b1, 1'b0, 32'h0000_0200, 3'd6, 4'hF), 32'h0, TO + 5, 32'h0, rc);
        chk("timeout_req_cycles", 64'(rc), 64'(TO));
        idle(1);

        // Ack on the very last wait cycle still completes normally.
        send_mem(mk(1'b1, 1'b1, 1'b0, 32'h0000_0300, 3'd2, 4'h3), 32'h0, TO - 1, 32'h0BAD_CAFE, rc);
        chk("late_ack_req_cycles", 64'(rc), 64'(TO));
        idle(1);

        // Read+write packet is treated as a load.
        send_mem(mk(1'b1, 1'b1, 1'b1, 32'h0000_0404, 3'd7, 4'h9), 32'h5555_AAAA, 1, 32'h1357_9BDF, rc);

        // Stray ack while idle is ignored.
        mem_ack = 1'b1;
        idle(1);
        mem_ack = 1'b0;
        chk("stray_ack_mem_req",  64'(mem_req),  64'd0);
        chk("stray_ack_in_ready", 64'(in_ready), 64'd1);
        idle(2);

        // Reset two cycles into ACCESS, then a late ack after release.
        in_valid = 1'b1;
        exec_in  = mk(1'b1, 1'b1, 1'b0, 32'h0000_0500, 3'd1, 4'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_mem_req", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_mem_req",  64'(mem_req),  64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_data_in",  64'(data_in),  64'd0);
        exp_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        idle(1);
        mem_ack = 1'b0;
        idle(4);
        chk("post_reset_mem_req",  64'(mem_req),  64'd0);
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        // Randomised mix of packet kinds, ack delays and gaps.
        for (int i = 0; i < 60; i++) begin
            logic [41:0] p;
            int kind;
            kind = $urandom_range(0, 3);
            p = mk(1'($urandom), 1'b0, 1'b0, $urandom, 3'($urandom), 4'($urandom));
            if (kind == 0) begin
                send_alu(p);
            end else begin
                p[1]  = (kind != 2);
                p[37] = (kind != 1);
                send_mem(p, $urandom, $urandom_range(0, TO + 2), $urandom, rc);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: TIMEOUT, default 16, maximum ACCESS-state cycles waited for mem_ack before abort (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  execute stage presents a packet.
REQ-005 in_ready  output  1  stage can accept a packet this cycle.
REQ-006 exec_in  input  42  execute packet: [0] we, [1] read_memory, [33:2] result/address, [36:34] dest, [37] write_memory, [41:38] reserved.
REQ-007 store_data  input  32  store operand, sampled with exec_in.
REQ-008 mem_req  output  1  memory request, held until mem_ack.
REQ-009 mem_we  output  1  1 = store, 0 = load.
REQ-010 mem_addr  output  32  byte address, equals captured exec_in[33:2].
REQ-011 mem_wdata  output  32  captured store_data.
REQ-012 mem_ack  input  1  memory completion, one-cycle pulse.
REQ-013 mem_rdata  input  32  load data, valid with mem_ack.
REQ-014 out_valid  output  1  one-cycle pulse: exec_out/data_in valid for writeback.
REQ-015 exec_out  output  42  registered packet, same layout as exec_in.
REQ-016 data_in  output  32  registered load data for writeback.
REQ-017 err  output  1  one-cycle pulse on access timeout.

Function
REQ-018 FSM states SHALL be IDLE and ACCESS; in_ready SHALL equal 1 exactly in IDLE.
REQ-019 Transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge.
REQ-020 Non-memory packet (bits 1 and 37 both 0): exec_out SHALL load exec_in and out_valid pulse on the next cycle; state stays IDLE; throughput one packet per cycle.
REQ-021 Memory packet (bit 1 or 37 set): SHALL capture packet and store_data, enter ACCESS, and assert mem_req in the cycle after transfer.
REQ-022 Packet with both bit 1 and bit 37 set SHALL be treated as a load; mem_we = 0.
REQ-023 mem_req, mem_we, mem_addr, mem_wdata SHALL be stable throughout ACCESS.
REQ-024 On mem_ack in ACCESS: mem_req deasserts next cycle; data_in loads mem_rdata for loads (unchanged for stores); exec_out loads captured packet; out_valid pulses next cycle; state returns to IDLE.
REQ-025 A 6-bit wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle without mem_ack.
REQ-026 When counter reaches TIMEOUT-1 without mem_ack: return to IDLE, deassert mem_req, pulse err and out_valid next cycle with exec_out bit 0 (we) forced to 0.
REQ-027 mem_ack in the same cycle as timeout SHALL win: normal completion, no err.
REQ-028 mem_ack outside ACCESS SHALL be ignored.
REQ-029 out_valid SHALL never be asserted in two consecutive cycles for a memory packet; no backpressure from writeback.
REQ-030 exec_out bits [41:38] SHALL pass through unchanged.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, mem_req 0, mem_we 0, out_valid 0, err 0, counter 0.
REQ-032 mem_addr, mem_wdata, exec_out, data_in SHALL reset to 0.
REQ-033 Reset during ACCESS SHALL abandon the access with no out_valid after release; a late mem_ack SHALL be ignored per REQ-028.

Structure
REQ-034 Shared package SHALL hold packet field positions (WE_BIT=0, RD_BIT=1, RES_LSB=2, RES_MSB=33, DEST_LSB=34, DEST_MSB=36, WR_BIT=37), packet width 42, and the FSM state encoding.
REQ-035 No sub-module; the wait counter and FSM are inline.

Verification
REQ-036 Back-to-back ALU packets, result 0x00000005 dest 3 then 0x0000000A dest 4 -> out_valid on two consecutive cycles, exec_out matching in order, mem_req never set.
REQ-037 Load addr 0x00000100, mem_ack 3 cycles after mem_req with rdata 0xDEADBEEF -> out_valid one cycle after ack, data_in 0xDEADBEEF, exec_out[36:34] preserved, in_ready 0 during ACCESS.
REQ-038 Store addr 0x00000040 data 0x12345678 -> mem_we 1, mem_wdata 0x12345678 held until ack, out_valid pulse, data_in unchanged.
REQ-039 Load with no ack, TIMEOUT=16 -> mem_req high 16 cycles, then err and out_valid pulse together, exec_out[0] 0.
REQ-040 mem_ack on the timeout cycle -> normal completion, err stays 0.
REQ-041 rst_n low 2 cycles into ACCESS, then ack after release -> mem_req 0 immediately, no out_valid, in_ready 1.
